// File: rtl/conv_12_mac_ctrl_pkg.sv
// conv_12_mac_ctrl_pkg: shared FSM state type, operand/product widths and defaults for the MAC controller
package conv_12_mac_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;
    localparam int PIX_W     = 16;
    localparam int WGT_W     = 8;
    localparam int PROD_W    = 24;
    localparam int LEN_W     = 8;
    localparam int ACC_W_DEF = 32;
endpackage

// File: rtl/conv_12_mac_ctrl_if.sv
// conv_12_mac_ctrl_if: operand-pair input stream and result output stream of the MAC controller
//   pix_tdata/wgt_tdata/in_tvalid/in_tready : signed operand pair stream into the block
//   res_tdata/res_tvalid/res_tready         : signed dot-product result stream out of the block
//   master drives operands and accepts results; slave is the MAC controller
interface conv_12_mac_ctrl_if
    import conv_12_mac_ctrl_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) ();
    logic signed [PIX_W-1:0] pix_tdata;
    logic signed [WGT_W-1:0] wgt_tdata;
    logic                    in_tvalid;
    logic                    in_tready;
    logic        [ACC_W-1:0] res_tdata;
    logic                    res_tvalid;
    logic                    res_tready;
    modport master (
        output pix_tdata, wgt_tdata, in_tvalid, res_tready,
        input  in_tready, res_tdata, res_tvalid
    );
    modport slave (
        input  pix_tdata, wgt_tdata, in_tvalid, res_tready,
        output in_tready, res_tdata, res_tvalid
    );
endinterface

// File: rtl/conv_12_mac_ctrl_mul.sv
// conv_12_mac_mul: combinational signed 16x8 multiplier with full-precision 24-bit product
//   a_i : signed pixel operand
//   b_i : signed weight operand
//   p_o : signed product
module conv_12_mac_mul
    import conv_12_mac_ctrl_pkg::*;
(
    input  logic signed [PIX_W-1:0]  a_i,
    input  logic signed [WGT_W-1:0]  b_i,
    output logic signed [PROD_W-1:0] p_o
);
    assign p_o = a_i * b_i;
endmodule

// File: rtl/conv_12_mac_ctrl.sv
// conv_12_mac_ctrl: runtime-length signed dot-product engine with start/ready/done control
//   ap_clk, ap_rst_n        : clock, asynchronous active-low reset
//   ap_start, len           : job start and pair count, sampled in IDLE (len clamped to MAX_LEN)
//   ap_idle, ap_ready, ap_done : idle level, last-pair-accepted pulse, result-handshake pulse
//   s                       : operand and result streams (conv_12_mac_ctrl_if.slave)
//   Build option CONV_12_MAC_RELU_EN clamps negative results to zero.
module conv_12_mac_ctrl
    import conv_12_mac_ctrl_pkg::*;
#(
    parameter int MAX_LEN = 255,
    parameter int ACC_W   = ACC_W_DEF
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ap_start,
    input  logic [LEN_W-1:0] len,
    output logic             ap_idle,
    output logic             ap_ready,
    output logic             ap_done,
    conv_12_mac_ctrl_if.slave s
);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN > 255 ? 255 : MAX_LEN);
    state_t                    state_q;
    logic        [LEN_W-1:0]   len_q;
    logic        [LEN_W-1:0]   cnt_q;
    logic signed [PROD_W-1:0]  prod_q;
    logic signed [PROD_W-1:0]  prod;
    logic                      pv_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic                      hs;
    logic                      last;
    conv_12_mac_mul u_mul (
        .a_i (s.pix_tdata),
        .b_i (s.wgt_tdata),
        .p_o (prod)
    );
    assign hs           = s.in_tvalid && s.in_tready;
    assign last         = hs && (cnt_q == len_q - 1'b1);
    assign s.in_tready  = state_q == ACC;
    assign s.res_tvalid = state_q == OUT;
    assign ap_idle      = state_q == IDLE;
    // zero-length jobs report ready in their start cycle; held low while reset is asserted
    assign ap_ready     = last || (ap_idle && ap_start && len == '0 && ap_rst_n);
    assign ap_done      = s.res_tvalid && s.res_tready;
`ifdef CONV_12_MAC_RELU_EN
    assign s.res_tdata  = s.res_tvalid && !acc_q[ACC_W-1] ? acc_q : '0;
`else
    assign s.res_tdata  = s.res_tvalid ? acc_q : '0;
`endif
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            pv_q    <= 1'b0;
            acc_q   <= '0;
        end else begin
            // product stage runs one cycle behind the handshake; DRAIN absorbs the last one
            pv_q <= hs;
            if (hs) prod_q <= prod;
            if (hs) cnt_q <= cnt_q + 1'b1;
            if (pv_q) acc_q <= acc_q + ACC_W'(prod_q);
            case (state_q)
                IDLE: if (ap_start) begin
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    len_q   <= len > MAX_L ? MAX_L : len;
                    state_q <= len == '0 ? OUT : ACC;
                end
                ACC:     if (last) state_q <= DRAIN;
                DRAIN:   state_q <= OUT;
                OUT:     if (s.res_tready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_12_mac_ctrl.sv
// tb_conv_12_mac_ctrl: randomized self-checking bench for conv_12_mac_ctrl against a sum-of-products model
module tb_conv_12_mac_ctrl;
    logic       ap_clk = 1'b0;
    logic       ap_rst_n = 1'b0;
    logic       ap_start = 1'b0;
    logic [7:0] len = '0;
    logic       ap_idle, ap_ready, ap_done;
    int vectors = 0;
    int miscompares = 0;
    int qpix[$];
    int qwgt[$];

    conv_12_mac_ctrl_if #(.ACC_W(32)) bus ();

    conv_12_mac_ctrl #(.MAX_LEN(255), .ACC_W(32)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .ap_start (ap_start),
        .len      (len),
        .ap_idle  (ap_idle),
        .ap_ready (ap_ready),
        .ap_done  (ap_done),
        .s        (bus.slave)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input int n);
        longint sum = 0;
        logic [31:0] r;
        for (int i = 0; i < n; i++) sum += longint'(qpix[i]) * longint'(qwgt[i]);
        r = sum[31:0];
`ifdef CONV_12_MAC_RELU_EN
        if (r[31]) r = '0;
`endif
        return r;
    endfunction

    task automatic run_job(input string nm, input int n, input int gap_pct, input int stall);
        logic [31:0] exp;
        int k = 0;
        int cyc = 0;
        bit v;
        exp = model(n);
        @(negedge ap_clk);
        ap_start = 1'b1;
        len = n[7:0];
        bus.in_tvalid = 1'b0;
        bus.res_tready = 1'b0;
        #1;
        vectors++;
        if (ap_idle !== 1'b1) begin miscompares++; $display("FAIL %s idle_at_start: got %b want 1", nm, ap_idle); end
        vectors++;
        if (ap_ready !== (n == 0)) begin miscompares++; $display("FAIL %s ready_at_start: got %b want %b", nm, ap_ready, n == 0); end
        @(negedge ap_clk);
        ap_start = 1'b0;
        if (n > 0) begin
            while (k < n && cyc < 4000) begin
                v = $urandom_range(99) >= gap_pct;
                bus.in_tvalid = v;
                bus.pix_tdata = v ? 16'(qpix[k]) : 16'($urandom);
                bus.wgt_tdata = v ? 8'(qwgt[k]) : 8'($urandom);
                ap_start = 1'($urandom);
                #1;
                vectors++;
                if (bus.in_tready !== 1'b1) begin miscompares++; $display("FAIL %s in_tready_acc: got %b want 1 (pair %0d)", nm, bus.in_tready, k); end
                if (v) k++;
                vectors++;
                if (ap_ready !== (v && k == n)) begin miscompares++; $display("FAIL %s ap_ready_acc: got %b want %b (pair %0d)", nm, ap_ready, v && k == n, k); end
                cyc++;
                @(negedge ap_clk);
            end
            if (k < n) begin
                vectors++;
                miscompares++;
                $display("FAIL %s accept_timeout: got %0d pairs want %0d", nm, k, n);
                ap_rst_n = 1'b0;
                @(negedge ap_clk);
                ap_rst_n = 1'b1;
                return;
            end
            bus.in_tvalid = 1'($urandom);
            ap_start = 1'($urandom);
            #1;
            vectors++;
            if (bus.in_tready !== 1'b0 || bus.res_tvalid !== 1'b0 || ap_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL %s drain_cycle: got tready=%b tvalid=%b ready=%b want 0 0 0", nm, bus.in_tready, bus.res_tvalid, ap_ready);
            end
            @(negedge ap_clk);
        end
        ap_start = 1'b0;
        bus.in_tvalid = 1'b1;
        for (int i = 0; i < stall; i++) begin
            bus.res_tready = 1'b0;
            #1;
            vectors++;
            if (bus.res_tvalid !== 1'b1 || bus.res_tdata !== exp || ap_done !== 1'b0 || bus.in_tready !== 1'b0) begin
                miscompares++;
                $display("FAIL %s out_stall: got tvalid=%b data=%h done=%b tready=%b want 1 %h 0 0", nm, bus.res_tvalid, bus.res_tdata, ap_done, bus.in_tready, exp);
            end
            @(negedge ap_clk);
        end
        bus.res_tready = 1'b1;
        #1;
        vectors++;
        if (bus.res_tvalid !== 1'b1 || bus.res_tdata !== exp || ap_done !== 1'b1 || bus.in_tready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s out_handshake: got tvalid=%b data=%h done=%b tready=%b want 1 %h 1 0", nm, bus.res_tvalid, bus.res_tdata, ap_done, bus.in_tready, exp);
        end
        @(negedge ap_clk);
        bus.in_tvalid = 1'b0;
        bus.res_tready = 1'b0;
        #1;
        vectors++;
        if (ap_idle !== 1'b1 || bus.res_tvalid !== 1'b0 || ap_done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s back_to_idle: got idle=%b tvalid=%b done=%b want 1 0 0", nm, ap_idle, bus.res_tvalid, ap_done);
        end
    endtask

    task automatic test_reset();
        bus.in_tvalid = 1'b0;
        bus.res_tready = 1'b0;
        bus.pix_tdata = '0;
        bus.wgt_tdata = '0;
        repeat (3) @(negedge ap_clk);
        #1;
        vectors++;
        if (ap_idle !== 1'b1 || ap_ready !== 1'b0 || ap_done !== 1'b0 || bus.in_tready !== 1'b0 || bus.res_tvalid !== 1'b0 || bus.res_tdata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state: got idle=%b ready=%b done=%b tready=%b tvalid=%b data=%h want 1 0 0 0 0 0", ap_idle, ap_ready, ap_done, bus.in_tready, bus.res_tvalid, bus.res_tdata);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    task automatic test_basic();
        qpix.delete(); qwgt.delete();
        for (int i = 1; i <= 9; i++) begin qpix.push_back(i); qwgt.push_back(1); end
        run_job("len9_sum45", 9, 0, 0);
    endtask

    task automatic test_corners();
        qpix = '{-32768, -32768}; qwgt = '{-128, -128};
        run_job("min_times_min", 2, 0, 0);
        qpix = '{100, 0, 1}; qwgt = '{-2, 5, 1};
        run_job("negative_sum", 3, 0, 1);
    endtask

    task automatic test_len_zero();
        qpix.delete(); qwgt.delete();
        run_job("len_zero", 0, 0, 2);
    endtask

    task automatic test_stall();
        qpix.delete(); qwgt.delete();
        for (int i = 0; i < 4; i++) begin qpix.push_back($urandom_range(65535) - 32768); qwgt.push_back($urandom_range(255) - 128); end
        run_job("gaps_and_stall", 4, 50, 5);
    endtask

    task automatic test_random();
        int n;
        for (int j = 0; j < 6; j++) begin
            n = $urandom_range(20, 1);
            qpix.delete(); qwgt.delete();
            for (int i = 0; i < n; i++) begin qpix.push_back($urandom_range(65535) - 32768); qwgt.push_back($urandom_range(255) - 128); end
            run_job("random_job", n, $urandom_range(40), $urandom_range(3));
        end
        qpix.delete(); qwgt.delete();
        for (int i = 0; i < 255; i++) begin qpix.push_back($urandom_range(65535) - 32768); qwgt.push_back($urandom_range(255) - 128); end
        run_job("len_255", 255, 10, 1);
    endtask

    task automatic test_reset_mid();
        @(negedge ap_clk);
        ap_start = 1'b1;
        len = 8'd9;
        @(negedge ap_clk);
        ap_start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            bus.in_tvalid = 1'b1;
            bus.pix_tdata = 16'(i);
            bus.wgt_tdata = 8'd1;
            @(negedge ap_clk);
        end
        bus.in_tvalid = 1'b0;
        ap_rst_n = 1'b0;
        #1;
        vectors++;
        if (ap_idle !== 1'b1 || bus.in_tready !== 1'b0 || bus.res_tvalid !== 1'b0 || bus.res_tdata !== 32'd0 || ap_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_acc: got idle=%b tready=%b tvalid=%b data=%h ready=%b want 1 0 0 0 0", ap_idle, bus.in_tready, bus.res_tvalid, bus.res_tdata, ap_ready);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        qpix = '{7}; qwgt = '{3};
        run_job("after_reset", 1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_len_zero();
        test_stall();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
